// File: rtl/rtc_bus_pkg.sv
// Shared encodings and default timing for the RTC burst bus controller.
// Combinational definitions only, no latency.
// No flow control lives here.
package rtc_bus_pkg;

    // Burst-level FSM encoding; kept as plain vectors for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CMD_PRE  = 3'd1;
    localparam state_t ST_ADDR     = 3'd2;
    localparam state_t ST_DATA     = 3'd3;
    localparam state_t ST_CMD_POST = 3'd4;
    localparam state_t ST_FIN      = 3'd5;

    // Phases of one bus cycle.
    typedef logic [1:0] phase_t;
    localparam phase_t PH_SETUP = 2'd0;
    localparam phase_t PH_PULSE = 2'd1;
    localparam phase_t PH_HOLD  = 2'd2;
    localparam phase_t PH_GAP   = 2'd3;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 8;
    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_PULSE   = 4;
    localparam int DEF_T_HOLD    = 2;
    localparam int DEF_T_GAP     = 2;
    localparam logic [7:0] DEF_CMD_BYTE = 8'hF0;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Sequences SETUP -> PULSE -> HOLD -> GAP for one RTC bus cycle.
// go on edge k puts SETUP in cycle k+1; cycle_end marks the last GAP cycle.
// No backpressure: go may be reissued on the cycle_end edge for back-to-back cycles.
module rtc_bus_phase_timer
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_GAP   = DEF_T_GAP
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   go,
    output phase_t phase,
    output logic   last,
    output logic   cycle_end
);

    localparam int T_MAX = max4(T_SETUP, T_PULSE, T_HOLD, T_GAP);
    localparam int CW    = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;

    logic [CW-1:0] cnt;
    logic          active;

    // Down-counter per phase; reloads from the next phase length when it hits zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            phase  <= PH_SETUP;
            cnt    <= '0;
        end else if (go) begin
            active <= 1'b1;
            phase  <= PH_SETUP;
            cnt    <= CW'(T_SETUP - 1);
        end else if (active) begin
            if (cnt == '0) begin
                case (phase)
                    PH_SETUP: begin phase <= PH_PULSE; cnt <= CW'(T_PULSE - 1); end
                    PH_PULSE: begin phase <= PH_HOLD;  cnt <= CW'(T_HOLD - 1);  end
                    PH_HOLD:  begin phase <= PH_GAP;   cnt <= CW'(T_GAP - 1);   end
                    default:  active <= 1'b0;
                endcase
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign last      = active && (cnt == '0);
    assign cycle_end = last && (phase == PH_GAP);

endmodule

// File: rtl/rtc_bus_burst_ctrl.sv
// Burst read/write engine for the RTC multiplexed address/data bus; optional RTC_CMD_EN adds a command cycle.
// Per word 2*(T_SETUP+T_PULSE+T_HOLD+T_GAP) cycles; done one cycle after the last bus cycle.
// start is dropped while busy (including the done cycle); wr_data is consumed on the wr_req cycle.
module rtc_bus_burst_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_PULSE   = DEF_T_PULSE,
    parameter int T_HOLD    = DEF_T_HOLD,
    parameter int T_GAP     = DEF_T_GAP
`ifdef RTC_CMD_EN
    ,
    parameter logic [DATA_W-1:0] CMD_BYTE = DATA_W'(DEF_CMD_BYTE)
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             rw,
    input  logic [DATA_W-1:0]                base_addr,
    input  logic [$clog2(BURST_MAX+1)-1:0]   count,
    input  logic [DATA_W-1:0]                wr_data,
    output logic                             wr_req,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             cs_n,
    output logic                             rd_n,
    output logic                             wr_n,
    output logic                             aod,
    inout  wire  [DATA_W-1:0]                bus
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    state_t             state, state_nxt;
    logic               rw_q;
    logic [DATA_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdat_q;
    logic [CNT_W-1:0]   words_left;
    logic [CNT_W-1:0]   count_clamped;
    logic               go;
    logic               first_q;
    phase_t             phase;
    logic               phase_last;
    logic               cycle_end;
    logic               in_cycle;
    logic               is_rd_data;
    logic               drive_en;
    logic [DATA_W-1:0]  bus_out;

    rtc_bus_phase_timer #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_GAP   (T_GAP)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .phase     (phase),
        .last      (phase_last),
        .cycle_end (cycle_end)
    );

    assign count_clamped = (count > CNT_W'(BURST_MAX)) ? CNT_W'(BURST_MAX) : count;

    // Next-state and timer launch: a new bus cycle starts on the edge that ends the previous one.
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (count_clamped == '0) begin
                        state_nxt = ST_FIN;
                    end else begin
                        go = 1'b1;
`ifdef RTC_CMD_EN
                        state_nxt = rw ? ST_CMD_PRE : ST_ADDR;
`else
                        state_nxt = ST_ADDR;
`endif
                    end
                end
            end
`ifdef RTC_CMD_EN
            ST_CMD_PRE: begin
                if (cycle_end) begin
                    state_nxt = ST_ADDR;
                    go        = 1'b1;
                end
            end
            ST_CMD_POST: begin
                if (cycle_end) state_nxt = ST_FIN;
            end
`endif
            ST_ADDR: begin
                if (cycle_end) begin
                    state_nxt = ST_DATA;
                    go        = 1'b1;
                end
            end
            ST_DATA: begin
                if (cycle_end) begin
                    if (words_left != CNT_W'(1)) begin
                        state_nxt = ST_ADDR;
                        go        = 1'b1;
`ifdef RTC_CMD_EN
                    end else if (!rw_q) begin
                        state_nxt = ST_CMD_POST;
                        go        = 1'b1;
`endif
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst context: captured with start, stepped once per completed data cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            words_left <= '0;
            first_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            first_q <= go;
            if (state == ST_IDLE && start) begin
                rw_q       <= rw;
                addr_q     <= base_addr;
                words_left <= count_clamped;
            end
            if (state == ST_DATA && cycle_end) begin
                addr_q     <= addr_q + DATA_W'(1);
                words_left <= words_left - CNT_W'(1);
            end
        end
    end

    assign is_rd_data = (state == ST_DATA) && rw_q;
    assign wr_req     = (state == ST_DATA) && !rw_q && first_q;

    // Data path: latch the write word on its request edge, sample the RTC at the end of the read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdat_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (wr_req) wdat_q <= wr_data;
            if (is_rd_data && phase == PH_PULSE && phase_last) begin
                rd_data  <= bus;
                rd_valid <= 1'b1;
            end
        end
    end

    // Strobes decode straight from registered state so reset clears them in the same cycle.
    assign in_cycle = (state != ST_IDLE) && (state != ST_FIN);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FIN);
    assign cs_n     = !(in_cycle && phase != PH_GAP);
    assign rd_n     = !(in_cycle && phase == PH_PULSE && is_rd_data);
    assign wr_n     = !(in_cycle && phase == PH_PULSE && !is_rd_data);
    assign aod      = (state == ST_DATA);
    assign drive_en = in_cycle && phase != PH_GAP && !is_rd_data;

    // Bus source; during the request cycle the incoming word is passed through before it is latched.
    always_comb begin
        bus_out = addr_q;
        if (state == ST_DATA) begin
            bus_out = wr_req ? wr_data : wdat_q;
`ifdef RTC_CMD_EN
        end else if (state == ST_CMD_PRE || state == ST_CMD_POST) begin
            bus_out = CMD_BYTE;
`endif
        end
    end

    assign bus = drive_en ? bus_out : {DATA_W{1'bz}};

endmodule

// File: tb/tb_rtc_bus_burst_ctrl.sv
// Directed bench for rtc_bus_burst_ctrl with a small RTC model and strobe scoreboard.
// Expected strobes/read words are queued when a burst is issued and popped as the bus shows them.
// Bursts are bounded by a cycle budget so a stuck DUT still reaches the summary.
module tb_rtc_bus_burst_ctrl;

    localparam int TP = 4;
`ifdef RTC_CMD_EN
    localparam int CTERM = 10;
    localparam bit CMD_ON = 1'b1;
`else
    localparam int CTERM = 0;
    localparam bit CMD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] kind;   // {aod, is_read}
        logic [7:0] val;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic [3:0] count = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_req, rd_valid, busy, done, cs_n, rd_n, wr_n, aod;
    logic [7:0] rd_data;
    wire  [7:0] bus;
    logic [7:0] rtc_val;

    int  vectors = 0;
    int  miscompares = 0;
    int  wr_cnt = 0, wr_plan = 0;
    int  rd_seen = 0, rd_plan = 0;
    sb_t exp_q[$];
    logic [7:0] rd_q[$];

    always #5 clk = ~clk;

    assign bus = (!rd_n) ? rtc_val : 8'hzz;

    rtc_bus_burst_ctrl dut (
        .clk(clk), .reset(rst), .start(start), .rw(rw), .base_addr(base_addr),
        .count(count), .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .cs_n(cs_n), .rd_n(rd_n),
        .wr_n(wr_n), .aod(aod), .bus(bus)
    );

    function automatic logic [7:0] wgen(input int i);
        return 8'h45 + 8'(i * 37);
    endfunction

    function automatic logic [7:0] rgen(input int i);
        return 8'((i + 1) * 17);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic plan(input logic r, input logic [7:0] a, input int m);
        logic [7:0] ad;
        ad = a;
        if (m > 0 && r && CMD_ON) exp_q.push_back('{kind: 2'b00, val: 8'hF0});
        for (int i = 0; i < m; i++) begin
            exp_q.push_back('{kind: 2'b00, val: ad});
            if (r) begin
                exp_q.push_back('{kind: 2'b11, val: 8'h00});
                rd_q.push_back(rgen(rd_plan));
                rd_plan++;
            end else begin
                exp_q.push_back('{kind: 2'b10, val: wgen(wr_plan)});
                wr_plan++;
            end
            ad = ad + 8'd1;
        end
        if (m > 0 && !r && CMD_ON) exp_q.push_back('{kind: 2'b00, val: 8'hF0});
    endtask

    task automatic burst(input string tag, input logic r, input logic [7:0] a, input int n, input int poke);
        int m, lat, exp_lat;
        m = (n > 8) ? 8 : n;
        exp_lat = (m > 0) ? m * 20 + CTERM : 0;
        plan(r, a, m);
        @(negedge clk);
        rw = r; base_addr = a; count = 4'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_k1"}, busy, 1);
        chk({tag, "_csn_k1"}, cs_n, (m > 0) ? 0 : 1);
        lat = 0;
        while (done !== 1'b1 && lat < 400) begin
            start = (lat == poke);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_lat"}, lat, exp_lat);
        // A start raised in the done cycle must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_fall"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_idle_csn"}, cs_n, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_strobes_left"}, exp_q.size(), 0);
        chk({tag, "_reads_left"}, rd_q.size(), 0);
    endtask

    initial begin
        rtc_val = rgen(0);
        fork
            begin : monitor
                logic prev_wr, prev_rd;
                int   lowc;
                sb_t  s;
                logic [7:0] e;
                prev_wr = 1'b1; prev_rd = 1'b1; lowc = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_wr = 1'b1; prev_rd = 1'b1; lowc = 0;
                        continue;
                    end
                    if (wr_req) begin
                        wr_data = wgen(wr_cnt);
                        wr_cnt++;
                    end
                    if (rd_valid) begin
                        if (rd_q.size() == 0) begin
                            chk("extra_rd_valid", 1, 0);
                        end else begin
                            e = rd_q.pop_front();
                            chk("rd_data", rd_data, e);
                        end
                        rd_seen++;
                        rtc_val = rgen(rd_seen);
                    end
                    if ((wr_n === 1'b0 && prev_wr) || (rd_n === 1'b0 && prev_rd)) begin
                        if (exp_q.size() == 0) begin
                            chk("extra_strobe", 1, 0);
                        end else begin
                            s = exp_q.pop_front();
                            chk("strobe_kind", {aod, ~rd_n}, s.kind);
                            if (s.kind[0]) chk("rd_bus_undriven", bus, rtc_val);
                            else chk("bus_val", bus, s.val);
                            chk("strobe_csn", cs_n, 0);
                        end
                    end
                    if (wr_n === 1'b0 || rd_n === 1'b0) begin
                        lowc++;
                    end else if (lowc != 0) begin
                        chk("pulse_width", lowc, TP);
                        lowc = 0;
                    end
                    prev_wr = wr_n;
                    prev_rd = rd_n;
                end
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csn", cs_n, 1);
        chk("rst_rdn", rd_n, 1);
        chk("rst_wrn", wr_n, 1);
        chk("rst_aod", aod, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrreq", wr_req, 0);
        chk("rst_rdvalid", rd_valid, 0);
        chk("rst_rddata", rd_data, 0);
        rst = 1'b0;

        burst("wr1", 1'b0, 8'h21, 1, -1);
        burst("rd3", 1'b1, 8'hFE, 3, -1);
        burst("cnt0", 1'b1, 8'h30, 0, -1);
        burst("cnt12", 1'b0, 8'h10, 12, 50);
        burst("rd_poke", 1'b1, 8'h80, 2, 5);

        // Reset during the strobe of the second word's address cycle.
        plan(1'b0, 8'h40, 3);
        @(negedge clk);
        rw = 1'b0; base_addr = 8'h40; count = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        chk("mid_wrn_low", wr_n, 0);
        chk("mid_aod", aod, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_csn", cs_n, 1);
        chk("mid_rst_wrn", wr_n, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        exp_q.delete();
        rd_q.delete();
        wr_plan = wr_cnt;
        rd_plan = rd_seen;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        burst("post_rst", 1'b1, 8'h05, 2, -1);
        burst("post_wr", 1'b0, 8'hFF, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
